// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard-sequencer state encoding, the canonical
// NOP instruction word and a small helper for recognising a data-cache miss.
package pipe_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_DSTALL     = 2'd1;
    localparam logic [1:0] ST_REDIR_WAIT = 2'd2;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h00000013;

    // A miss is an issued access that the data cache does not complete now.
    function automatic logic dmem_miss(input logic req, input logic ready);
        return req && !ready;
    endfunction

endpackage

// File: rtl/hazard_loaduse_det.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a load currently in EX. Writes to x0 never create a hazard.
module hazard_loaduse_det #(
    parameter int REG_AW = 5
) (
    input  logic              i_ex_is_load,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    output logic              o_hazard
);

    logic w_rd_nonzero;
    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_rd_nonzero = (i_ex_rd != '0);
    assign w_hit_rs1    = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_hit_rs2    = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    assign o_hazard     = i_ex_is_load && w_rd_nonzero && (w_hit_rs1 || w_hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pause/flush sequencer for the five-stage pipeline.
// Outputs are combinational from registered state plus current inputs.
// Optional performance counters: define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imem_ready,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_br_taken,
    input  logic [XLEN-1:0]   ex_br_target,
    output logic              pc_pause,
    output logic              pc_redirect,
    output logic [XLEN-1:0]   pc_redirect_target,
    output logic              if_id_pause,
    output logic              if_id_flush,
    output logic              id_ex_pause,
    output logic              id_ex_flush,
    output logic              ex_mem_pause,
    output logic              mem_wb_flush
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cycles,
    output logic [PERF_W-1:0] perf_flush_count,
    output logic [PERF_W-1:0] perf_loaduse_count
`endif
);

    state_t          r_state;
    logic [XLEN-1:0] r_target;
    logic            r_pending;

    state_t          w_next_state;
    logic [XLEN-1:0] w_next_target;
    logic            w_next_pending;
    logic            w_miss;
    logic            w_loaduse;
    logic            w_loaduse_bubble;

    assign w_miss = dmem_miss(dmem_req, dmem_ready);

    hazard_loaduse_det #(
        .REG_AW (REG_AW)
    ) u_loaduse (
        .i_ex_is_load (ex_is_load),
        .i_ex_rd      (ex_rd),
        .i_id_rs1     (id_rs1),
        .i_id_rs2     (id_rs2),
        .i_id_use_rs1 (id_use_rs1),
        .i_id_use_rs2 (id_use_rs2),
        .o_hazard     (w_loaduse)
    );

    // Decode stage controls and next state; priority is dmem miss > redirect > load-use.
    always_comb begin
        pc_pause           = 1'b0;
        pc_redirect        = 1'b0;
        pc_redirect_target = '0;
        if_id_pause        = 1'b0;
        if_id_flush        = 1'b0;
        id_ex_pause        = 1'b0;
        id_ex_flush        = 1'b0;
        ex_mem_pause       = 1'b0;
        mem_wb_flush       = 1'b0;
        w_loaduse_bubble   = 1'b0;
        w_next_state       = r_state;
        w_next_target      = r_target;
        w_next_pending     = r_pending;

        if (!rst_n) begin
            // Keep bubbles flowing into ID/EX while the core is held in reset.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_miss) begin
                        pc_pause       = 1'b1;
                        if_id_pause    = 1'b1;
                        id_ex_pause    = 1'b1;
                        ex_mem_pause   = 1'b1;
                        mem_wb_flush   = 1'b1;
                        w_next_state   = ST_DSTALL;
                        w_next_pending = 1'b0;
                    end else if (ex_br_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (imem_ready) begin
                            pc_redirect        = 1'b1;
                            pc_redirect_target = ex_br_target;
                        end else begin
                            // Fetch cannot accept the new PC yet: remember it.
                            pc_pause      = 1'b1;
                            w_next_target = ex_br_target;
                            w_next_state  = ST_REDIR_WAIT;
                        end
                    end else if (w_loaduse) begin
                        pc_pause         = 1'b1;
                        if_id_pause      = 1'b1;
                        id_ex_flush      = 1'b1;
                        w_loaduse_bubble = 1'b1;
                    end
                end
                ST_REDIR_WAIT: begin
                    if (w_miss) begin
                        pc_pause       = 1'b1;
                        if_id_pause    = 1'b1;
                        id_ex_pause    = 1'b1;
                        ex_mem_pause   = 1'b1;
                        mem_wb_flush   = 1'b1;
                        w_next_state   = ST_DSTALL;
                        w_next_pending = 1'b1;
                    end else begin
                        // Anything fetched meanwhile is wrong-path; never let it reach ID.
                        if_id_flush = 1'b1;
                        if (imem_ready) begin
                            pc_redirect        = 1'b1;
                            pc_redirect_target = r_target;
                            w_next_state       = ST_RUN;
                        end else begin
                            pc_pause = 1'b1;
                        end
                    end
                end
                ST_DSTALL: begin
                    if (dmem_ready) begin
                        w_next_state   = r_pending ? ST_REDIR_WAIT : ST_RUN;
                        w_next_pending = 1'b0;
                    end else begin
                        pc_pause     = 1'b1;
                        if_id_pause  = 1'b1;
                        id_ex_pause  = 1'b1;
                        ex_mem_pause = 1'b1;
                        mem_wb_flush = 1'b1;
                    end
                end
                default: begin
                    w_next_state   = ST_RUN;
                    w_next_pending = 1'b0;
                end
            endcase
        end
    end

    // Register sequencer state, the held redirect target and the pending-redirect flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_target  <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_target  <= w_next_target;
            r_pending <= w_next_pending;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Saturating event counters for stall cycles, redirects and load-use bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cycles  <= '0;
            perf_flush_count   <= '0;
            perf_loaduse_count <= '0;
        end else begin
            if (pc_pause)         perf_stall_cycles  <= sat_inc(perf_stall_cycles);
            if (pc_redirect)      perf_flush_count   <= sat_inc(perf_flush_count);
            if (w_loaduse_bubble) perf_loaduse_count <= sat_inc(perf_loaduse_count);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Build with PIPE_HAZARD_CTRL_PERF_EN to also check the performance counters.
module tb_pipe_hazard_ctrl;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int PERF_W = 32;

    // Output vector bit order:
    // {pc_pause, pc_redirect, if_id_pause, if_id_flush, id_ex_pause, id_ex_flush, ex_mem_pause, mem_wb_flush}
    localparam logic [7:0] O_IDLE    = 8'h00;
    localparam logic [7:0] O_RESET   = 8'h14;
    localparam logic [7:0] O_LOADUSE = 8'hA4;
    localparam logic [7:0] O_BR_REDIR= 8'h54;
    localparam logic [7:0] O_BR_WAIT = 8'h94;
    localparam logic [7:0] O_RW_WAIT = 8'h90;
    localparam logic [7:0] O_RW_REDIR= 8'h50;
    localparam logic [7:0] O_STALL   = 8'hAB;

    logic              clk;
    logic              rst_n;
    logic              imem_ready;
    logic              dmem_req;
    logic              dmem_ready;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_br_taken;
    logic [XLEN-1:0]   ex_br_target;
    logic              pc_pause;
    logic              pc_redirect;
    logic [XLEN-1:0]   pc_redirect_target;
    logic              if_id_pause;
    logic              if_id_flush;
    logic              id_ex_pause;
    logic              id_ex_flush;
    logic              ex_mem_pause;
    logic              mem_wb_flush;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_stall_cycles;
    logic [PERF_W-1:0] perf_flush_count;
    logic [PERF_W-1:0] perf_loaduse_count;
`endif

    logic [7:0] outs;
    assign outs = {pc_pause, pc_redirect, if_id_pause, if_id_flush,
                   id_ex_pause, id_ex_flush, ex_mem_pause, mem_wb_flush};

    int n_chk = 0;
    int n_bad = 0;

    pipe_hazard_ctrl #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW),
        .PERF_W (PERF_W)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .imem_ready         (imem_ready),
        .dmem_req           (dmem_req),
        .dmem_ready         (dmem_ready),
        .id_rs1             (id_rs1),
        .id_rs2             (id_rs2),
        .id_use_rs1         (id_use_rs1),
        .id_use_rs2         (id_use_rs2),
        .ex_is_load         (ex_is_load),
        .ex_rd              (ex_rd),
        .ex_br_taken        (ex_br_taken),
        .ex_br_target       (ex_br_target),
        .pc_pause           (pc_pause),
        .pc_redirect        (pc_redirect),
        .pc_redirect_target (pc_redirect_target),
        .if_id_pause        (if_id_pause),
        .if_id_flush        (if_id_flush),
        .id_ex_pause        (id_ex_pause),
        .id_ex_flush        (id_ex_flush),
        .ex_mem_pause       (ex_mem_pause),
        .mem_wb_flush       (mem_wb_flush)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .perf_stall_cycles  (perf_stall_cycles),
        .perf_flush_count   (perf_flush_count),
        .perf_loaduse_count (perf_loaduse_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic br, input logic [XLEN-1:0] tgt, input logic im,
                         input logic req, input logic rdy);
        ex_br_taken  = br;
        ex_br_target = tgt;
        imem_ready   = im;
        dmem_req     = req;
        dmem_ready   = rdy;
    endtask

    task automatic set_lu(input logic ld, input logic [REG_AW-1:0] rd,
                          input logic [REG_AW-1:0] rs1, input logic u1,
                          input logic [REG_AW-1:0] rs2, input logic u2);
        ex_is_load = ld;
        ex_rd      = rd;
        id_rs1     = rs1;
        id_use_rs1 = u1;
        id_rs2     = rs2;
        id_use_rs2 = u2;
    endtask

    // Inputs are already applied; check the combinational outputs, then advance one clock.
    task automatic step(input string tag, input logic [7:0] exp_outs);
        #1;
        chk(tag, {24'h0, outs}, {24'h0, exp_outs});
        chk({tag, "_excl"}, {30'h0, if_id_pause & if_id_flush, id_ex_pause & id_ex_flush}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        set_lu(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

        // Reset
        #1;
        chk("rst_target", pc_redirect_target, 32'h0);
        step("rst_outs", O_RESET);
        rst_n = 1'b1;
        step("idle_after_rst", O_IDLE);

        // Load-use
        set_lu(1'b1, 5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
        step("lu_rs2_x5", O_LOADUSE);
        set_lu(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        step("lu_rd_x0", O_IDLE);
        set_lu(1'b1, 5'd5, 5'd3, 1'b1, 5'd5, 1'b0);
        step("lu_rs2_unused", O_IDLE);
        set_lu(1'b0, 5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
        step("lu_not_load", O_IDLE);

        // Taken branch, fetch ready; a simultaneous load-use must not pause
        set_lu(1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
        drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        #1;
        chk("br100_target", pc_redirect_target, 32'h100);
        step("br100_outs", O_BR_REDIR);
        set_lu(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("br100_stay_run", O_IDLE);

        // Taken branch with fetch not ready for 3 cycles
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        step("br200_c1", O_BR_WAIT);
        drive(1'b0, 32'hdead, 1'b0, 1'b0, 1'b0);
        set_lu(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        step("br200_c2", O_RW_WAIT);
        set_lu(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step("br200_c3", O_RW_WAIT);
        drive(1'b0, 32'hdead, 1'b1, 1'b0, 1'b0);
        #1;
        chk("br200_target", pc_redirect_target, 32'h200);
        step("br200_c4", O_RW_REDIR);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("br200_run", O_IDLE);

        // Data-cache miss of 5 cycles with a branch held in the frozen EX stage
        drive(1'b1, 32'h300, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("dstall_c%0d", i + 1), O_STALL);
        end
        drive(1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
        step("dstall_release", O_IDLE);
        drive(1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
        #1;
        chk("br300_target", pc_redirect_target, 32'h300);
        step("br300_after", O_BR_REDIR);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("br300_idle", O_IDLE);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        chk("perf_loaduse", perf_loaduse_count, 32'd1);
        chk("perf_flush", perf_flush_count, 32'd3);
        chk("perf_stall", perf_stall_cycles, 32'd9);
`endif

        // Data-cache miss while a redirect is pending
        drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
        step("br400_c1", O_BR_WAIT);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        step("br400_miss", O_STALL);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
        step("br400_release", O_IDLE);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("br400_target", pc_redirect_target, 32'h400);
        step("br400_redir", O_RW_REDIR);
        step("br400_idle", O_IDLE);

        // Reset in REDIR_WAIT drops the latched target
        drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
        step("br500_c1", O_BR_WAIT);
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step("br500_rst", O_RESET);
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("br500_dropped1", O_IDLE);
        step("br500_dropped2", O_IDLE);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        chk("perf_flush_clr", perf_flush_count, 32'd0);
        chk("perf_stall_clr", perf_stall_cycles, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
